// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rpn_pkg
// Purpose  : Operator codes shared with the converter, evaluator state encoding
// Revision : 1.0
// ============================================================================
package rpn_pkg;

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_EMIT = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } rpn_state_e;

endpackage
`default_nettype wire

// File: rtl/rpn_if.sv
`default_nettype none
// ============================================================================
// Module   : rpn_if
// Purpose  : Token input and result output strobe/ack handshakes
// Revision : 1.0
// ============================================================================
interface rpn_if #(
  parameter int WIDTH = 32
) ();

  logic             token_stb;
  logic [WIDTH-1:0] token_data;
  logic             token_is_operator;
  logic             token_ack;
  logic             result_stb;
  logic [WIDTH-1:0] result_data;
  logic             result_error;
  logic             result_ack;

  // Producer/consumer side
  modport master (
    output token_stb, token_data, token_is_operator, result_ack,
    input  token_ack, result_stb, result_data, result_error
  );

  // Evaluator side
  modport slave (
    input  token_stb, token_data, token_is_operator, result_ack,
    output token_ack, result_stb, result_data, result_error
  );

endinterface
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// ============================================================================
// Module   : rpn_alu
// Purpose  : Combinational two's complement '*', '+', '-' on two operands
// Revision : 1.0
// ============================================================================
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_MUL:  result = a * b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rpn_evaluator.sv
`default_nettype none
// ============================================================================
// Module   : rpn_evaluator
// Purpose  : Postfix token sequencer driving an operand stack and the ALU
// Revision : 1.0
// ============================================================================
module rpn_evaluator
  import rpn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  rpn_if.slave                       bus,
  output logic [$clog2(DEPTH+1)-1:0] stack_depth
);

  localparam int c_DW = $clog2(DEPTH + 1);
  localparam int c_AW = $clog2(DEPTH);

  rpn_state_e       r_state;
  rpn_state_e       w_state_nxt;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [c_DW-1:0]  r_depth;
  logic [WIDTH-1:0] r_tok_data;
  logic             r_tok_is_op;
  logic             r_commit;
  logic [c_AW-1:0]  r_wr_idx;
  logic [WIDTH-1:0] r_wr_data;
  logic [c_DW-1:0]  r_new_depth;
  logic             r_result_stb;
  logic [WIDTH-1:0] r_result_data;
  logic             r_result_error;
  logic             r_token_ack;

  logic [2:0]       w_code;
  logic [c_AW-1:0]  w_top_idx;
  logic [c_AW-1:0]  w_next_idx;
  logic [c_AW-1:0]  w_push_idx;
  logic             w_full;
  logic [WIDTH-1:0] w_alu;

  logic             w_latch;
  logic             w_emit;
  logic             w_err;
  logic             w_commit;
  logic [c_AW-1:0]  w_wr_idx;
  logic [WIDTH-1:0] w_wr_data;
  logic [c_DW-1:0]  w_new_depth;
  logic [WIDTH-1:0] w_res_data;
  logic             w_clr;
  logic             w_ack_nxt;

  assign w_code     = r_tok_data[2:0];
  assign w_push_idx = r_depth[c_AW-1:0];
  assign w_top_idx  = r_depth[c_AW-1:0] - c_AW'(1);
  assign w_next_idx = r_depth[c_AW-1:0] - c_AW'(2);
  assign w_full     = (r_depth == c_DW'(DEPTH));

  // a is the entry below the top, b is the top of stack
  rpn_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (r_stack[w_next_idx]),
    .b      (r_stack[w_top_idx]),
    .op     (w_code),
    .result (w_alu)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.token_stb) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = w_emit ? ST_EMIT : ST_DONE;
      ST_EMIT: if (r_result_stb && bus.result_ack) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_HOLD;
      ST_HOLD: if (!bus.token_stb) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_latch     = 1'b0;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_commit    = 1'b0;
    w_wr_idx    = '0;
    w_wr_data   = '0;
    w_new_depth = r_depth;
    w_res_data  = '0;
    w_clr       = 1'b0;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: w_latch = bus.token_stb;
      ST_EXEC: begin
        if (!r_tok_is_op) begin
          if (w_full) begin
            w_err = 1'b1;
          end else begin
            w_commit    = 1'b1;
            w_wr_idx    = w_push_idx;
            w_wr_data   = r_tok_data;
            w_new_depth = r_depth + c_DW'(1);
          end
        end else begin
          case (w_code)
            OP_MUL, OP_ADD, OP_SUB: begin
              if (r_depth < c_DW'(2)) begin
                w_err = 1'b1;
              end else begin
                w_commit    = 1'b1;
                w_wr_idx    = w_next_idx;
                w_wr_data   = w_alu;
                w_new_depth = r_depth - c_DW'(1);
              end
            end
            OP_EQ: begin
              if (r_depth == c_DW'(1)) begin
                w_emit     = 1'b1;
                w_res_data = r_stack[0];
              end else begin
                w_err = 1'b1;
              end
            end
            default: w_err = 1'b1;
          endcase
        end
        if (w_err) w_emit = 1'b1;
      end
      ST_EMIT: w_clr     = r_result_stb && bus.result_ack;
      ST_DONE: w_ack_nxt = 1'b1;
      default: ;
    endcase
  end

  // Stack updates land one cycle after EXEC so depth moves with token_ack
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_depth        <= '0;
      r_tok_data     <= '0;
      r_tok_is_op    <= 1'b0;
      r_commit       <= 1'b0;
      r_wr_idx       <= '0;
      r_wr_data      <= '0;
      r_new_depth    <= '0;
      r_result_stb   <= 1'b0;
      r_result_data  <= '0;
      r_result_error <= 1'b0;
      r_token_ack    <= 1'b0;
    end else begin
      r_token_ack <= w_ack_nxt;
      if (w_latch) begin
        r_tok_data  <= bus.token_data;
        r_tok_is_op <= bus.token_is_operator;
      end
      if (r_state == ST_EXEC) begin
        r_commit    <= w_commit;
        r_wr_idx    <= w_wr_idx;
        r_wr_data   <= w_wr_data;
        r_new_depth <= w_new_depth;
        if (w_emit) begin
          r_result_data  <= w_res_data;
          r_result_error <= w_err;
        end
      end
      if (r_state == ST_DONE && r_commit) begin
        r_depth  <= r_new_depth;
        r_commit <= 1'b0;
      end
      if (r_state == ST_EMIT && !r_result_stb) r_result_stb <= 1'b1;
      if (w_clr) begin
        r_result_stb   <= 1'b0;
        r_result_data  <= '0;
        r_result_error <= 1'b0;
        r_depth        <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && r_state == ST_DONE && r_commit) r_stack[r_wr_idx] <= r_wr_data;
  end

  assign bus.token_ack    = r_token_ack;
  assign bus.result_stb   = r_result_stb;
  assign bus.result_data  = r_result_data;
  assign bus.result_error = r_result_error;
  assign stack_depth      = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_rpn_evaluator.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpn_evaluator
// Purpose  : Directed scoreboard bench for rpn_evaluator
// Revision : 1.0
// ============================================================================
module tb_rpn_evaluator;
  import rpn_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } res_t;

  logic       clk;
  logic       rst;
  logic [4:0] depth;
  int         n_chk;
  int         n_fail;
  res_t       sb[$];

  rpn_if #(.WIDTH(32)) bus ();

  rpn_evaluator #(
    .DEPTH (16),
    .WIDTH (32)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus.slave),
    .stack_depth (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic take_result();
    res_t e;
    chk("result_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("result_data", bus.result_data, e.data);
      chk("result_error", 32'(bus.result_error), 32'(e.err));
    end
  endtask

  // Called at each negedge: take a pending result and acknowledge it once
  task automatic service_result();
    if (bus.result_stb) begin
      take_result();
      bus.result_ack = 1'b1;
    end else begin
      bus.result_ack = 1'b0;
    end
  endtask

  task automatic send(input logic op, input logic [31:0] d, input int exp_depth, input int linger);
    bit got;
    int extra;
    bus.token_stb         = 1'b1;
    bus.token_data        = d;
    bus.token_is_operator = op;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      service_result();
      if (bus.token_ack) got = 1'b1;
    end
    chk("token_ack", 32'(got), 32'd1);
    chk("stack_depth", 32'(depth), 32'(exp_depth));
    extra = 0;
    for (int c = 0; c < linger; c++) begin
      @(negedge clk);
      if (bus.token_ack) extra++;
    end
    if (linger > 0) chk("no_reaccept", 32'(extra), 32'd0);
    bus.token_stb = 1'b0;
    @(negedge clk);
    bus.result_ack = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] d, input logic e);
    sb.push_back('{data: d, err: e});
  endtask

  initial begin
    bit seen;
    bit stable;
    int early;
    n_chk  = 0;
    n_fail = 0;
    rst                   = 1'b1;
    bus.token_stb         = 1'b0;
    bus.token_data        = '0;
    bus.token_is_operator = 1'b0;
    bus.result_ack        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result_stb", 32'(bus.result_stb), 32'd0);
    chk("rst_token_ack", 32'(bus.token_ack), 32'd0);
    chk("rst_result_data", bus.result_data, 32'd0);
    chk("rst_result_error", 32'(bus.result_error), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3 4 + = -> 7
    send(1'b0, 32'd3, 1, 0);
    send(1'b0, 32'd4, 2, 0);
    send(1'b1, 32'(OP_ADD), 1, 0);
    expect_res(32'd7, 1'b0);
    send(1'b1, 32'(OP_EQ), 0, 0);

    // 5 3 - 2 * = -> 4
    send(1'b0, 32'd5, 1, 0);
    send(1'b0, 32'd3, 2, 0);
    send(1'b1, 32'(OP_SUB), 1, 0);
    send(1'b0, 32'd2, 2, 0);
    send(1'b1, 32'(OP_MUL), 1, 0);
    expect_res(32'd4, 1'b0);
    send(1'b1, 32'(OP_EQ), 0, 0);

    // Signed overflow wraps
    send(1'b0, 32'h7FFF_FFFF, 1, 0);
    send(1'b0, 32'd1, 2, 0);
    send(1'b1, 32'(OP_ADD), 1, 0);
    expect_res(32'h8000_0000, 1'b0);
    send(1'b1, 32'(OP_EQ), 0, 0);

    // Product keeps the low word only
    send(1'b0, 32'h0001_0000, 1, 0);
    send(1'b0, 32'h0001_0000, 2, 0);
    send(1'b1, 32'(OP_MUL), 1, 0);
    expect_res(32'd0, 1'b0);
    send(1'b1, 32'(OP_EQ), 0, 0);

    // Underflow
    send(1'b0, 32'd5, 1, 0);
    expect_res(32'd0, 1'b1);
    send(1'b1, 32'(OP_ADD), 0, 0);

    // Overflow: 16 fit, the 17th errors
    for (int i = 1; i <= 16; i++) send(1'b0, 32'(i), i, 0);
    expect_res(32'd0, 1'b1);
    send(1'b0, 32'd17, 0, 0);

    // '=' with two operands
    send(1'b0, 32'd1, 1, 0);
    send(1'b0, 32'd2, 2, 0);
    expect_res(32'd0, 1'b1);
    send(1'b1, 32'(OP_EQ), 0, 0);

    // Invalid operator code
    send(1'b0, 32'd9, 1, 0);
    expect_res(32'd0, 1'b1);
    send(1'b1, 32'h0000_0006, 0, 0);

    // Strobe held 6 cycles past token_ack
    send(1'b0, 32'd9, 1, 6);
    chk("linger_depth", 32'(depth), 32'd1);
    expect_res(32'd9, 1'b0);
    send(1'b1, 32'(OP_EQ), 0, 0);

    // Delayed result_ack
    send(1'b0, 32'd42, 1, 0);
    expect_res(32'd42, 1'b0);
    bus.token_stb         = 1'b1;
    bus.token_data        = 32'(OP_EQ);
    bus.token_is_operator = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.result_stb) seen = 1'b1;
    end
    chk("dly_result_stb", 32'(seen), 32'd1);
    take_result();
    stable = 1'b1;
    early  = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.result_stb !== 1'b1 || bus.result_data !== 32'd42 || bus.result_error !== 1'b0) stable = 1'b0;
      if (bus.token_ack) early++;
    end
    chk("dly_stable", 32'(stable), 32'd1);
    chk("dly_no_early_ack", 32'(early), 32'd0);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    chk("dly_stb_fell", 32'(bus.result_stb), 32'd0);
    chk("dly_depth_clear", 32'(depth), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.token_ack) seen = 1'b1;
    end
    chk("dly_token_ack", 32'(seen), 32'd1);
    bus.token_stb = 1'b0;
    @(negedge clk);

    // Reset while a result is pending
    send(1'b0, 32'd5, 1, 0);
    expect_res(32'd5, 1'b0);
    bus.token_stb         = 1'b1;
    bus.token_data        = 32'(OP_EQ);
    bus.token_is_operator = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.result_stb) seen = 1'b1;
    end
    chk("emit_rst_stb_seen", 32'(seen), 32'd1);
    take_result();
    rst           = 1'b1;
    bus.token_stb = 1'b0;
    @(negedge clk);
    chk("emit_rst_result_stb", 32'(bus.result_stb), 32'd0);
    chk("emit_rst_token_ack", 32'(bus.token_ack), 32'd0);
    chk("emit_rst_depth", 32'(depth), 32'd0);
    rst = 1'b0;
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.token_ack) early++;
    end
    chk("emit_rst_no_ack", 32'(early), 32'd0);
    send(1'b0, 32'd1, 1, 0);
    expect_res(32'd1, 1'b0);
    send(1'b1, 32'(OP_EQ), 0, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
